// File: rtl/fifo_sync_1w_2r.sv
// fifo_sync_1w_2r: synchronous FIFO with one write port and two compacting
// read ports. Read data is show-ahead; pops and the write commit on the same
// rising edge, and reads only see words stored before that edge.
module fifo_sync_1w_2r #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         datain,
    input  logic                     wr_en,
    input  logic [1:0]               rd_ens,
    output logic [WIDTH-1:0]         dataout0,
    output logic [WIDTH-1:0]         dataout1,
    output logic [1:0]               rd_valids,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_p1;
    logic [CW-1:0]    req;
    logic [CW-1:0]    grant;
    logic             accepted;
    logic [CW-1:0]    count_next;

    assign rd_ptr_p1 = rd_ptr + AW'(1);

    // Lane grants, compacted read data, and write acceptance for this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd_valids = 2'b00;
        case (rd_ens)
            2'b01:   rd_valids = {1'b0, count >= CW'(1)};
            2'b10:   rd_valids = {count >= CW'(1), 1'b0};
            2'b11:   rd_valids = {count >= CW'(2), count >= CW'(1)};
            default: rd_valids = 2'b00;
        endcase

        // Lane 0 always shows the oldest word; lane 1 shows it only when it
        // is the sole enabled lane, otherwise the second-oldest word.
        dataout0 = mem[rd_ptr];
        dataout1 = (rd_ens == 2'b10) ? mem[rd_ptr] : mem[rd_ptr_p1];

        req        = CW'(rd_ens[0]) + CW'(rd_ens[1]);
        grant      = CW'(rd_valids[0]) + CW'(rd_valids[1]);
        // A full FIFO still takes a write when at least one pop frees a slot.
        accepted   = wr_en && ((count < CW'(DEPTH)) || (grant != '0));
        count_next = count - grant + CW'(accepted);
    end

    // Storage array: cleared on reset, written at wr_ptr on an accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is explicitly cleared so the show-ahead
            // outputs read a defined 0 after reset rather than stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accepted) begin
            mem[wr_ptr] <= datain;
        end
    end

    // Pointers, occupancy, status and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr + AW'(grant);
            wr_ptr    <= wr_ptr + AW'(accepted);
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == CW'(DEPTH));
            overflow  <= overflow | (wr_en & ~accepted);
            underflow <= underflow | (req > grant);
        end
    end

endmodule

// File: tb/tb_fifo_sync_1w_2r.sv
// tb_fifo_sync_1w_2r: directed, self-checking bench for fifo_sync_1w_2r with
// the default WIDTH=32, DEPTH=4. Inputs change on the falling edge and all
// outputs are sampled 1 ns after it, well away from the rising edge.
module tb_fifo_sync_1w_2r;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] datain;
    logic             wr_en;
    logic [1:0]       rd_ens;
    logic [WIDTH-1:0] dataout0;
    logic [WIDTH-1:0] dataout1;
    logic [1:0]       rd_valids;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int vectors;
    int miscompares;

    fifo_sync_1w_2r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .datain    (datain),
        .wr_en     (wr_en),
        .rd_ens    (rd_ens),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .rd_valids (rd_valids),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance across one rising edge and land 1 ns after the next falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [WIDTH-1:0] d, input logic [1:0] r);
        wr_en  = w;
        datain = d;
        rd_ens = r;
        #0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_ens = 2'b00;
        datain = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_do0", dataout0, 32'h0);
        check("rst_do1", dataout1, 32'h0);
        check("rst_rdv", 32'(rd_valids), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);

        // Fill with A0..A3, then a dropped write of FF.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 2'b00);
            tick();
        end
        check("fill_full_pre", 32'(full), 32'd1);
        drive(1'b1, 32'hFF, 2'b00);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_do0", dataout0, 32'hA0);
        check("fill_do1", dataout1, 32'hA1);
        check("fill_udf", 32'(underflow), 32'd0);

        // Dual pops drain the full FIFO in two cycles.
        drive(1'b0, '0, 2'b11);
        #1;
        check("dual1_do0", dataout0, 32'hA0);
        check("dual1_do1", dataout1, 32'hA1);
        check("dual1_rdv", 32'(rd_valids), 32'b11);
        tick();
        check("dual2_do0", dataout0, 32'hA2);
        check("dual2_do1", dataout1, 32'hA3);
        check("dual2_rdv", 32'(rd_valids), 32'b11);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        check("drain_udf", 32'(underflow), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Lane-1-only pop takes the oldest word.
        drive(1'b1, 32'hB0, 2'b00);
        tick();
        drive(1'b1, 32'hB1, 2'b00);
        tick();
        drive(1'b0, '0, 2'b10);
        #1;
        check("l1_do1", dataout1, 32'hB0);
        check("l1_rdv", 32'(rd_valids), 32'b10);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("l1_count", 32'(count), 32'd1);
        check("l1_peek", dataout0, 32'hB1);
        drive(1'b0, '0, 2'b01);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("l1_empty", 32'(empty), 32'd1);

        // Full FIFO accepts a write alongside a single pop.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 2'b00);
            tick();
        end
        drive(1'b1, 32'hC4, 2'b01);
        #1;
        check("fpw_rdv", 32'(rd_valids), 32'b01);
        check("fpw_do0", dataout0, 32'hC0);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("fpw_count", 32'(count), 32'd4);
        check("fpw_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 2'b01);
            #1;
            check("fpw_pop_do0", dataout0, 32'hC1 + 32'(i));
            check("fpw_pop_rdv", 32'(rd_valids), 32'b01);
            tick();
        end
        drive(1'b0, '0, 2'b00);
        #1;
        check("fpw_empty", 32'(empty), 32'd1);
        check("fpw_udf", 32'(underflow), 32'd0);

        // count=1, dual pop with a write: only lane 0 granted.
        drive(1'b1, 32'hD0, 2'b00);
        tick();
        drive(1'b1, 32'hD1, 2'b11);
        #1;
        check("c1_rdv", 32'(rd_valids), 32'b01);
        check("c1_do0", dataout0, 32'hD0);
        check("c1_do1_peek", dataout1, 32'hC2);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("c1_udf", 32'(underflow), 32'd1);
        check("c1_count", 32'(count), 32'd1);
        check("c1_do0_next", dataout0, 32'hD1);

        // Reset with contents discards everything and clears the flags.
        rst = 1'b1;
        drive(1'b1, 32'hEE, 2'b11);
        tick();
        rst = 1'b0;
        drive(1'b0, '0, 2'b00);
        #1;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_udf", 32'(underflow), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_do0", dataout0, 32'h0);
        check("mrst_do1", dataout1, 32'h0);

        // Empty FIFO with write and pop: no grant, write lands, underflow set.
        drive(1'b1, 32'hE0, 2'b01);
        #1;
        check("ewr_rdv", 32'(rd_valids), 32'b00);
        tick();
        drive(1'b0, '0, 2'b00);
        #1;
        check("ewr_count", 32'(count), 32'd1);
        check("ewr_udf", 32'(underflow), 32'd1);
        check("ewr_do0", dataout0, 32'hE0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_sync_1w_2r.md
Name: fifo_sync_1w_2r

Overview:
Synchronous FIFO with one write port and two read ports per cycle. It is the drain-side counterpart to the two-write/one-read FIFO. A producer pushes at most one word per cycle, and up to two consumers pop 0, 1 or 2 words per cycle. Read lanes are compacted in lane order: the k-th enabled lane receives the k-th oldest stored word. It feeds dual-issue consumers, for example two output ports draining one queue.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 4, number of entries; must be a power of 2 and at least 2

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
datain  input  WIDTH  write data
wr_en  input  1  write request
rd_ens  input  2  per-lane pop requests; bit k = lane k
dataout0  output  WIDTH  lane-0 read data (show-ahead, combinational)
dataout1  output  WIDTH  lane-1 read data (show-ahead, combinational)
rd_valids  output  2  bit k = lane k pop granted this cycle (combinational)
count  output  $clog2(DEPTH)+1  stored entries (registered)
empty  output  1  count==0 (registered)
full  output  1  count==DEPTH (registered)
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a requested pop was not granted

Behaviour:
- Reset (rst=1 at a clk edge):
  - rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, overflow=0, underflow=0.
  - Storage array cleared to 0, so dataout0 and dataout1 read 0 after reset.
  - Reset overrides every simultaneous wr_en and rd_ens. Reset mid-traffic discards all contents.
- Read side. Reads see only entries stored before this edge; there is no write-to-read bypass.
  - req = popcount(rd_ens).
  - grant = min(req, count).
  - Lane order: lower-index enabled lane first.
- Lane data and grants by rd_ens:
  - 2'b01: dataout0=mem[rd_ptr]; rd_valids[0]=(count>=1).
  - 2'b10: dataout1=mem[rd_ptr]; rd_valids[1]=(count>=1).
  - 2'b11: dataout0=mem[rd_ptr], dataout1=mem[rd_ptr+1]. rd_valids[0]=(count>=1), rd_valids[1]=(count>=2).
  - 2'b00: dataout0=mem[rd_ptr], dataout1=mem[rd_ptr+1] (peek only); rd_valids=0.
  - Lanes not granted still drive the peek value. Consumers must qualify data with rd_valids.
- Write side.
  - Write accepted when wr_en=1 and (count<DEPTH or grant>=1). A full FIFO with a simultaneous pop accepts the write.
  - Accepted write stores datain at mem[wr_ptr].
  - wr_en=1 but not accepted: the write is dropped and overflow is set.
- Pointer and count update:
  - rd_ptr += grant, mod DEPTH.
  - wr_ptr += accepted, mod DEPTH. Both pointers wrap naturally through log2(DEPTH) bits.
  - count_next = count - grant + accepted. Never negative, never above DEPTH.
- Flags:
  - underflow set when req > grant.
  - overflow and underflow stay set until rst.
  - empty and full are recomputed from count_next and registered together with count.
- Simultaneous events:
  - Empty FIFO with wr_en=1 and rd_ens!=0: write accepted, no grant, underflow set. The word is readable on the next cycle.
  - count=1, rd_ens=2'b11, wr_en=1: lane 0 granted, lane 1 not granted, underflow set, write accepted, count_next=1.
- Latency: a word written at edge N is poppable in the cycle after edge N, i.e. one cycle of write-to-read latency.

Test Plan:
- Reset then idle, DEPTH=4 -> count=0, empty=1, full=0, dataout0=dataout1=0, rd_valids=00, flags 0.
- Write 0xA0,0xA1,0xA2,0xA3 on 4 cycles, then wr_en=1 datain=0xFF with no reads -> full=1, count=4, 0xFF dropped, overflow=1, dataout0=0xA0, dataout1=0xA1.
- Full FIFO, rd_ens=11 for two cycles -> 0xA0/0xA1, then 0xA2/0xA3, rd_valids=11 both cycles. Pointers wrap to 0, empty=1, underflow=0.
- count=2 holding 0xB0,0xB1, rd_ens=10 -> dataout1=0xB0, rd_valids=10. Next cycle count=1 and dataout0 peeks 0xB1.
- Full FIFO holding 0xC0..0xC3, wr_en=1 datain=0xC4, rd_ens=01 -> 0xC0 granted, write accepted, count stays 4. Subsequent pops return 0xC1,0xC2,0xC3,0xC4.
- count=1 holding 0xD0, rd_ens=11, wr_en=1 datain=0xD1 -> rd_valids=01, dataout0=0xD0, underflow=1, count_next=1. Then assert rst with FIFO non-empty -> count=0, empty=1, underflow=0 on the next cycle.
